// File: rtl/load_align_unit.sv
// Load path for the memory stage: issues word-aligned reads (two for a misaligned
// access), then extracts and sign/zero-extends the addressed bytes.
module load_align_unit #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned WAIT_LIMIT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        split_q;
    logic [7:0]  cnt_q;
    logic [31:0] word0_q;
    logic [31:0] word1_q;
    logic        mem_re_q;
    logic [31:0] mem_addr_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_split;
    logic        rvalid_ok;
    logic        waited_out;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [63:0] shifted;
    logic [31:0] load_d;

    // Classify the incoming request before it is captured.
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        req_split      = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_legal = 1'b1;
            3'b001, 3'b101: begin
                req_legal      = 1'b1;
                req_misaligned = req_addr[0];
                req_split      = (req_addr[1:0] == 2'b11);
            end
            3'b010: begin
                req_legal      = 1'b1;
                req_misaligned = (req_addr[1:0] != 2'b00);
                req_split      = (req_addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Data arriving now completes the access, so the result is built from it directly.
    always_comb begin
        lo_word = (state_q == RD1) ? word0_q : mem_rdata;
        hi_word = (state_q == RD1) ? mem_rdata : 32'h0;
        shifted = {hi_word, lo_word} >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_d = {24'h0, shifted[7:0]};
            3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_d = {16'h0, shifted[15:0]};
            3'b010:  load_d = shifted[31:0];
            default: load_d = 32'h0;
        endcase
    end

    // Data returned in the same cycle as the strobe belongs to no read of ours.
    assign rvalid_ok  = mem_rvalid && !mem_re_q;
    assign waited_out = (cnt_q == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            split_q      <= 1'b0;
            cnt_q        <= 8'h0;
            word0_q      <= 32'h0;
            word1_q      <= 32'h0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            mem_re_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        offset_q <= req_addr[1:0];
                        split_q  <= req_split;
                        word1_q  <= 32'h0;
                        if (!req_legal || (req_misaligned && !ALLOW_MISALIGNED)) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= 32'h0;
                        end else begin
                            state_q    <= RD0;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                            cnt_q      <= 8'h0;
                        end
                    end
                end
                RD0, RD1: begin
                    if (rvalid_ok) begin
                        if (state_q == RD0) begin
                            word0_q <= mem_rdata;
                        end else begin
                            word1_q <= mem_rdata;
                        end
                        if (state_q == RD0 && split_q) begin
                            state_q    <= RD1;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= mem_addr_q + 32'd4;
                            cnt_q      <= 8'h0;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_data_q  <= load_d;
                        end
                    end else if (!mem_re_q) begin
                        if (waited_out) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= 32'h0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign stall      = (state_q != IDLE);
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a default instance plus one with misaligned
// accesses disallowed, each backed by a small memory answering one cycle after mem_re.
module tb_load_align_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_valid_na;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mute;

    logic        req_ready, mem_re, resp_valid, resp_err, stall;
    logic [31:0] mem_addr, resp_data;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready_n, mem_re_n, resp_valid_n, resp_err_n, stall_n;
    logic [31:0] mem_addr_n, resp_data_n;
    logic        mem_rvalid_n;
    logic [31:0] mem_rdata_n;

    int compared;
    int mismatched;

    load_align_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .stall(stall)
    );

    load_align_unit #(.ALLOW_MISALIGNED(1'b0), .WAIT_LIMIT(255)) dut_na (
        .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_ready(req_ready_n),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_re(mem_re_n),
        .mem_addr(mem_addr_n), .mem_rvalid(mem_rvalid_n), .mem_rdata(mem_rdata_n),
        .resp_valid(resp_valid_n), .resp_data(resp_data_n), .resp_err(resp_err_n),
        .stall(stall_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'h8765_4321;
            32'h0000_0104: mem_word = 32'hCAFE_BABE;
            default:       mem_word = 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        mem_rvalid   <= mem_re && !mute;
        mem_rdata    <= mem_word(mem_addr);
        mem_rvalid_n <= mem_re_n;
        mem_rdata_n  <= mem_word(mem_addr_n);
    end

    // Issue one load and follow it to its response; lat counts cycles after the accept edge.
    task automatic do_load(input bit na, input logic [31:0] addr, input logic [2:0] f3,
                           output logic [31:0] data, output logic err, output int lat,
                           output int nre, output logic [31:0] a0, output logic [31:0] a1);
        @(posedge clk); #1;
        req_addr   = addr;
        req_funct3 = f3;
        if (na) req_valid_na = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_valid_na = 1'b0;
        lat = 1; nre = 0; a0 = 32'hx; a1 = 32'hx;
        while (lat < 400) begin
            if (na ? mem_re_n : mem_re) begin
                if (nre == 0) a0 = na ? mem_addr_n : mem_addr;
                else          a1 = na ? mem_addr_n : mem_addr;
                nre++;
            end
            if (na ? resp_valid_n : resp_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        data = na ? resp_data_n : resp_data;
        err  = na ? resp_err_n : resp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared += 7;
        if (req_ready !== 1'b1)    begin mismatched++; $display("[TB] FAIL reset_ready got %b want 1", req_ready); end
        if (stall !== 1'b0)        begin mismatched++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
        if (mem_re !== 1'b0)       begin mismatched++; $display("[TB] FAIL reset_mem_re got %b want 0", mem_re); end
        if (mem_addr !== 32'h0)    begin mismatched++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
        if (resp_valid !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
        if (resp_data !== 32'h0)   begin mismatched++; $display("[TB] FAIL reset_resp_data got %h want 0", resp_data); end
        if (resp_err !== 1'b0)     begin mismatched++; $display("[TB] FAIL reset_resp_err got %b want 0", resp_err); end
        rst = 1'b0;
    endtask

    // Aligned and sub-word loads: one read, response three cycles after accept.
    task automatic test_single_read();
        logic [31:0] d, a0, a1;
        logic        e;
        int          lat, nre;
        logic [31:0] addrs [4]  = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [2:0]  f3s   [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4]  = '{32'hFFFF_FF87, 32'h0000_0087, 32'hFFFF_8765, 32'h0000_4321};
        for (int i = 0; i < 4; i++) begin
            do_load(1'b0, addrs[i], f3s[i], d, e, lat, nre, a0, a1);
            compared += 5;
            if (d !== exps[i])     begin mismatched++; $display("[TB] FAIL single_data[%0d] got %h want %h", i, d, exps[i]); end
            if (e !== 1'b0)        begin mismatched++; $display("[TB] FAIL single_err[%0d] got %b want 0", i, e); end
            if (lat !== 3)         begin mismatched++; $display("[TB] FAIL single_latency[%0d] got %0d want 3", i, lat); end
            if (nre !== 1)         begin mismatched++; $display("[TB] FAIL single_reads[%0d] got %0d want 1", i, nre); end
            if (a0 !== 32'h100)    begin mismatched++; $display("[TB] FAIL single_addr[%0d] got %h want 100", i, a0); end
        end
        @(posedge clk); #1;
        compared += 2;
        if (resp_valid !== 1'b0)      begin mismatched++; $display("[TB] FAIL hold_valid got %b want 0", resp_valid); end
        if (resp_data !== 32'h0000_4321) begin mismatched++; $display("[TB] FAIL hold_data got %h want 00004321", resp_data); end
    endtask

    // Misaligned loads crossing a word boundary, including the top-of-memory wrap.
    task automatic test_split();
        logic [31:0] d, a0, a1;
        logic        e;
        int          lat, nre;
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'hFFFF_FFFD};
        logic [2:0]  f3s   [3] = '{3'b010, 3'b001, 3'b010};
        logic [31:0] exps  [3] = '{32'hBE87_6543, 32'hFFFF_BE87, 32'h0};
        logic [31:0] ea0   [3] = '{32'h100, 32'h100, 32'hFFFF_FFFC};
        logic [31:0] ea1   [3] = '{32'h104, 32'h104, 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_load(1'b0, addrs[i], f3s[i], d, e, lat, nre, a0, a1);
            compared += 6;
            if (d !== exps[i])  begin mismatched++; $display("[TB] FAIL split_data[%0d] got %h want %h", i, d, exps[i]); end
            if (e !== 1'b0)     begin mismatched++; $display("[TB] FAIL split_err[%0d] got %b want 0", i, e); end
            if (lat !== 5)      begin mismatched++; $display("[TB] FAIL split_latency[%0d] got %0d want 5", i, lat); end
            if (nre !== 2)      begin mismatched++; $display("[TB] FAIL split_reads[%0d] got %0d want 2", i, nre); end
            if (a0 !== ea0[i])  begin mismatched++; $display("[TB] FAIL split_addr0[%0d] got %h want %h", i, a0, ea0[i]); end
            if (a1 !== ea1[i])  begin mismatched++; $display("[TB] FAIL split_addr1[%0d] got %h want %h", i, a1, ea1[i]); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, a0, a1;
        logic        e;
        int          lat, nre;
        do_load(1'b0, 32'h100, 3'b011, d, e, lat, nre, a0, a1);
        compared += 4;
        if (e !== 1'b1)    begin mismatched++; $display("[TB] FAIL illegal_err got %b want 1", e); end
        if (d !== 32'h0)   begin mismatched++; $display("[TB] FAIL illegal_data got %h want 0", d); end
        if (nre !== 0)     begin mismatched++; $display("[TB] FAIL illegal_reads got %0d want 0", nre); end
        if (lat !== 1)     begin mismatched++; $display("[TB] FAIL illegal_latency got %0d want 1", lat); end
        do_load(1'b1, 32'h102, 3'b010, d, e, lat, nre, a0, a1);
        compared += 3;
        if (e !== 1'b1)    begin mismatched++; $display("[TB] FAIL nomisal_err got %b want 1", e); end
        if (d !== 32'h0)   begin mismatched++; $display("[TB] FAIL nomisal_data got %h want 0", d); end
        if (nre !== 0)     begin mismatched++; $display("[TB] FAIL nomisal_reads got %0d want 0", nre); end
        do_load(1'b1, 32'h100, 3'b010, d, e, lat, nre, a0, a1);
        compared += 2;
        if (d !== 32'h8765_4321) begin mismatched++; $display("[TB] FAIL nomisal_aligned_data got %h want 87654321", d); end
        if (e !== 1'b0)          begin mismatched++; $display("[TB] FAIL nomisal_aligned_err got %b want 0", e); end
    endtask

    task automatic test_timeout();
        logic [31:0] d, a0, a1;
        logic        e;
        int          lat, nre;
        mute = 1'b1;
        do_load(1'b0, 32'h100, 3'b000, d, e, lat, nre, a0, a1);
        compared += 4;
        if (e !== 1'b1)   begin mismatched++; $display("[TB] FAIL timeout_err got %b want 1", e); end
        if (d !== 32'h0)  begin mismatched++; $display("[TB] FAIL timeout_data got %h want 0", d); end
        if (lat < 255 || lat > 258) begin mismatched++; $display("[TB] FAIL timeout_latency got %0d want 255..258", lat); end
        if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_stall_resp got %b want 1", stall); end
        @(posedge clk); #1;
        compared += 1;
        if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_stall_after got %b want 0", stall); end
        mute = 1'b0;
    endtask

    // Abort a split load during its second read; the stale data that follows must be dropped.
    task automatic test_reset_midop();
        logic [31:0] d, a0, a1;
        logic        e;
        int          lat, nre, n;
        bit          seen;
        @(posedge clk); #1;
        req_addr = 32'h101; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (mem_re && mem_addr == 32'h104) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        compared += 1;
        if (!seen) begin mismatched++; $display("[TB] FAIL midop_reach_rd1 got 0 want 1"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        compared += 3;
        if (req_ready !== 1'b1)  begin mismatched++; $display("[TB] FAIL midop_ready got %b want 1", req_ready); end
        if (stall !== 1'b0)      begin mismatched++; $display("[TB] FAIL midop_stall got %b want 0", stall); end
        if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midop_resp got %b want 0", resp_valid); end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid) n++;
        end
        compared += 1;
        if (n !== 0) begin mismatched++; $display("[TB] FAIL midop_late_resp got %0d want 0", n); end
        do_load(1'b0, 32'h104, 3'b010, d, e, lat, nre, a0, a1);
        compared += 2;
        if (d !== 32'hCAFE_BABE) begin mismatched++; $display("[TB] FAIL midop_next_data got %h want cafebabe", d); end
        if (lat !== 3)           begin mismatched++; $display("[TB] FAIL midop_next_latency got %0d want 3", lat); end
    endtask

    // req_valid held high: the second request is accepted only once back in IDLE.
    task automatic test_back_to_back();
        int hits[$];
        int busy_ready;
        @(posedge clk); #1;
        req_addr = 32'h103; req_funct3 = 3'b100; req_valid = 1'b1;
        @(posedge clk); #1;
        busy_ready = 0;
        for (int c = 1; c <= 8; c++) begin
            if (resp_valid) hits.push_back(c);
            if ((c >= 1 && c <= 3 || c >= 5 && c <= 7) && req_ready) busy_ready++;
            if (c < 8) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
        compared += 4;
        if (hits.size() !== 2) begin mismatched++; $display("[TB] FAIL b2b_count got %0d want 2", hits.size()); end
        if (hits.size() > 0 && hits[0] !== 3) begin mismatched++; $display("[TB] FAIL b2b_first got %0d want 3", hits[0]); end
        else if (hits.size() == 0) begin mismatched++; $display("[TB] FAIL b2b_first got none want 3"); end
        if (hits.size() > 1 && hits[1] !== 7) begin mismatched++; $display("[TB] FAIL b2b_second got %0d want 7", hits[1]); end
        else if (hits.size() < 2) begin mismatched++; $display("[TB] FAIL b2b_second got none want 7"); end
        if (busy_ready !== 0) begin mismatched++; $display("[TB] FAIL b2b_ready_busy got %0d want 0", busy_ready); end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1; mute = 1'b0;
        req_valid = 1'b0; req_valid_na = 1'b0;
        req_addr = 32'h0; req_funct3 = 3'b000;
        test_reset();
        test_single_read();
        test_split();
        test_errors();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
